// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: IF-stage fetch PC owner, in-order instruction memory requester and {pc, instr} FIFO toward decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_dropped event counters.
module if_fetch_buffer #(
    parameter int N      = 32,
    parameter int DEPTH  = 4,
    parameter int PC_INC = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req_valid,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_resp_valid,
    input  logic [N-1:0] imem_resp_data,
    output logic         dec_valid,
    output logic [N-1:0] dec_pc,
    output logic [N-1:0] dec_instr,
    input  logic         dec_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_dropped
`endif
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Stale responses can pile up across several redirects ahead of a slow memory.
    localparam int DROP_W = CNT_W + 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [N-1:0]      fetch_pc;
    logic [N-1:0]      resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_cnt_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [N-1:0]      pc_mem    [DEPTH];
    logic [N-1:0]      instr_mem [DEPTH];
    logic [CNT_W:0]    credits_used;

    logic              run;
    logic              flush;
    logic              req_fire;
    logic              resp_keep;
    logic              resp_drop;
    logic              deq;

    function automatic logic [N-1:0] pc_step(input logic [N-1:0] pc);
        return pc + N'(PC_INC);
    endfunction

    assign run          = (state == RUN);
    assign flush        = run && redirect_valid;
    assign credits_used = {1'b0, outstanding} + {1'b0, count};
    assign req_fire     = imem_req_valid && imem_req_ready;
    assign resp_drop    = imem_resp_valid && (drop_cnt != '0);
    assign resp_keep    = run && imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign deq          = dec_valid && dec_ready;

    // Control FSM: one idle cycle after reset, then fetch until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN:  imem_req_valid = !redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));
            default: state_next = IDLE;
        endcase
    end

    // Request/response accounting; a redirect converts every live request into a stale one.
    always_comb begin
        outstanding_next = outstanding;
        drop_cnt_next    = drop_cnt;
        count_next       = count;
        if (flush) begin
            outstanding_next = '0;
            drop_cnt_next    = drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_resp_valid);
            count_next       = '0;
        end else begin
            if (resp_drop) begin
                drop_cnt_next = drop_cnt - DROP_W'(1);
            end
            outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_keep);
            count_next       = count + CNT_W'(resp_keep) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= '0;
            resp_pc     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            count       <= count_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= pc_step(fetch_pc);
                end
                if (resp_keep) begin
                    resp_pc <= pc_step(resp_pc);
                end
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (resp_keep) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage carries data only and needs no reset; outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (resp_keep) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

    assign imem_req_addr = fetch_pc;
    assign dec_valid     = (count != '0);
    assign dec_pc        = dec_valid ? pc_mem[rd_ptr]    : '0;
    assign dec_instr     = dec_valid ? instr_mem[rd_ptr] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flushed_entries;
    logic [31:0] dropped_resps;

    // An entry dequeued in the redirect cycle is delivered, not flushed.
    always_comb begin
        flushed_entries = '0;
        if (flush) begin
            flushed_entries = 32'(count) - 32'(deq);
        end
        dropped_resps = 32'(resp_drop || (flush && imem_resp_valid));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(deq);
            perf_dropped <= perf_dropped + flushed_entries + dropped_resps;
        end
    end
`endif

endmodule
